// File: rtl/bram_wr_arbiter.sv
// bram_wr_arbiter: two-port BRAM write arbiter with sticky ownership and a bounded burst length
// Grants are combinational; the winning write is registered onto the BRAM port one cycle later.
module bram_wr_arbiter #(
    parameter int ABITS    = 8,
    parameter int DBITS    = 64,
    parameter int MAXBURST = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [ABITS-1:0] req0_addr,
    input  logic [DBITS-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [ABITS-1:0] req1_addr,
    input  logic [DBITS-1:0] req1_data,
    output logic             req1_ready,
    output logic [ABITS-1:0] wr_addr,
    output logic [DBITS-1:0] wr_data,
    output logic             wr_en,
    output logic [1:0]       owner
);
    typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;
    localparam logic [7:0] MAX = 8'(MAXBURST);
    state_t     state, state_n;
    logic       prio, prio_n;
    logic [7:0] cnt, cnt_n;
    logic       keep0, keep1, grant, same;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            prio    <= 1'b0;
            cnt     <= 8'd0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state <= state_n;
            prio  <= prio_n;
            cnt   <= cnt_n;
            wr_en <= grant;
            if (grant) begin
                wr_addr <= req0_ready ? req0_addr : req1_addr;
                wr_data <= req0_ready ? req0_data : req1_data;
            end
        end
    end
    // The owner keeps the port unless the other side is waiting and the burst is spent
    always_comb begin
        keep0      = req0_valid && (!req1_valid || cnt < MAX);
        keep1      = req1_valid && (!req0_valid || cnt < MAX);
        req0_ready = rst && (state == OWN0 ? keep0 :
                             state == OWN1 ? req0_valid && !keep1 :
                             req0_valid && (!req1_valid || !prio));
        req1_ready = rst && (state == OWN1 ? keep1 :
                             state == OWN0 ? req1_valid && !keep0 :
                             req1_valid && (!req0_valid || prio));
    end
    always_comb begin
        grant   = req0_ready || req1_ready;
        same    = (req0_ready && state == OWN0) || (req1_ready && state == OWN1);
        state_n = req0_ready ? OWN0 : req1_ready ? OWN1 : IDLE;
        cnt_n   = !grant ? 8'd0 : !same ? 8'd1 : cnt < MAX ? cnt + 8'd1 : MAX;
        prio_n  = (state == OWN0 && !req0_ready) ? !req1_ready :
                  (state == OWN1 && !req1_ready) ? req0_ready : prio;
    end
    assign owner = state;
endmodule

// File: tb/tb_bram_wr_arbiter.sv
// tb_bram_wr_arbiter: directed and randomized checks of two arbiters (MAXBURST 4 and 1)
module tb_bram_wr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    logic        v0[2], v1[2], r0[2], r1[2], we[2];
    logic [7:0]  a0[2], a1[2], wa[2];
    logic [63:0] d0[2], d1[2], wd[2];
    logic [1:0]  ow[2];
    int checks = 0;
    int errors = 0;
    int mb[2] = '{4, 1};
    int m_own[2], m_run[2], m_pr[2], m_g[2];
    logic        m_we[2];
    logic [7:0]  m_wa[2];
    logic [63:0] m_wd[2];
    int         gseq[10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    logic [7:0] aseq[6]  = '{8'h00, 8'h80, 8'h01, 8'h81, 8'h02, 8'h82};

    bram_wr_arbiter #(.ABITS(8), .DBITS(64), .MAXBURST(4)) dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(v0[0]), .req0_addr(a0[0]), .req0_data(d0[0]), .req0_ready(r0[0]),
        .req1_valid(v1[0]), .req1_addr(a1[0]), .req1_data(d1[0]), .req1_ready(r1[0]),
        .wr_addr(wa[0]), .wr_data(wd[0]), .wr_en(we[0]), .owner(ow[0]));
    bram_wr_arbiter #(.ABITS(8), .DBITS(64), .MAXBURST(1)) dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(v0[1]), .req0_addr(a0[1]), .req0_data(d0[1]), .req0_ready(r0[1]),
        .req1_valid(v1[1]), .req1_addr(a1[1]), .req1_data(d1[1]), .req1_ready(r1[1]),
        .wr_addr(wa[1]), .wr_data(wd[1]), .wr_en(we[1]), .owner(ow[1]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Which port the arbitration rules pick this cycle (-1: nobody)
    function automatic int pick(input int i);
        int k;
        bit vk, vo;
        if (!rst) return -1;
        if (m_own[i] == 0) return (v0[i] && v1[i]) ? m_pr[i] : v0[i] ? 0 : v1[i] ? 1 : -1;
        k  = m_own[i] - 1;
        vk = k ? v1[i] : v0[i];
        vo = k ? v0[i] : v1[i];
        if (vk && (!vo || m_run[i] < mb[i])) return k;
        return vo ? 1 - k : -1;
    endfunction

    task automatic tick();
        #3;
        for (int i = 0; i < 2; i++) begin
            int g;
            string s;
            g = pick(i);
            s = i ? "b" : "a";
            chk({s, ".ready0"}, 64'(r0[i]), 64'(g == 0));
            chk({s, ".ready1"}, 64'(r1[i]), 64'(g == 1));
            chk({s, ".owner"}, 64'(ow[i]), 64'(m_own[i]));
            chk({s, ".wr_en"}, 64'(we[i]), 64'(m_we[i]));
            chk({s, ".wr_addr"}, 64'(wa[i]), 64'(m_wa[i]));
            chk({s, ".wr_data"}, wd[i], m_wd[i]);
            if (!rst) begin
                m_own[i] = 0; m_pr[i] = 0; m_run[i] = 0;
                m_we[i] = 1'b0; m_wa[i] = '0; m_wd[i] = '0;
            end else if (g >= 0) begin
                m_run[i] = (m_own[i] == g + 1) ? (m_run[i] < mb[i] ? m_run[i] + 1 : mb[i]) : 1;
                if (m_own[i] != 0 && m_own[i] != g + 1) m_pr[i] = m_own[i] - 1;
                m_own[i] = g + 1;
                m_we[i] = 1'b1;
                m_wa[i] = g ? a1[i] : a0[i];
                m_wd[i] = g ? d1[i] : d0[i];
            end else begin
                if (m_own[i] != 0) m_pr[i] = 2 - m_own[i];
                m_own[i] = 0;
                m_we[i] = 1'b0;
            end
            m_g[i] = g;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input bit p0, input bit p1, input logic [7:0] x0, input logic [7:0] x1,
                         input logic [63:0] y0, input logic [63:0] y1);
        v0[i] = p0; v1[i] = p1; a0[i] = x0; a1[i] = x1; d0[i] = y0; d1[i] = y1;
    endtask

    task automatic both(input bit p0, input bit p1, input logic [7:0] x0, input logic [7:0] x1,
                        input logic [63:0] y0, input logic [63:0] y1);
        drive(0, p0, p1, x0, x1, y0, y1);
        drive(1, p0, p1, x0, x1, y0, y1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        both(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        both(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            m_own[i] = 0; m_run[i] = 0; m_pr[i] = 0; m_g[i] = -1;
            m_we[i] = 1'b0; m_wa[i] = '0; m_wd[i] = '0;
        end
        @(posedge clk);
        #1;
        do_reset();
        // Single requester on port 1 from idle
        both(0, 1, 8'h00, 8'h10, 64'h0, 64'hA5);
        #1 chk("r030.ready1", 64'(r1[0]), 64'd1);
        tick();
        both(0, 0, 0, 0, 0, 0);
        #1 chk("r030.wr_en", 64'(we[0]), 64'd1);
        chk("r030.wr_addr", 64'(wa[0]), 64'h10);
        chk("r030.wr_data", wd[0], 64'hA5);
        chk("r030.owner", 64'(ow[0]), 64'd2);
        tick();
        // Both contending: burst of four then hand-over; MAXBURST=1 alternates
        do_reset();
        drive(0, 1, 1, 8'h20, 8'h21, 64'h1111, 64'h2222);
        drive(1, 1, 1, 8'h00, 8'h80, 64'h3333, 64'h4444);
        for (int c = 0; c < 10; c++) begin
            #1 chk("r031.ready0", 64'(r0[0]), 64'(gseq[c] == 0));
            chk("r031.ready1", 64'(r1[0]), 64'(gseq[c] == 1));
            if (c > 0) chk("r031.wr_en", 64'(we[0]), 64'd1);
            if (c > 0 && c <= 6) chk("r035.wr_addr", 64'(wa[1]), 64'(aseq[c-1]));
            tick();
            if (m_g[1] == 0) a0[1] = a0[1] + 8'd1;
            if (m_g[1] == 1) a1[1] = a1[1] + 8'd1;
        end
        #1 chk("r031.wr_en_last", 64'(we[0]), 64'd1);
        both(0, 0, 0, 0, 0, 0);
        tick();
        // Port 0 drops, port 1 takes over with no bubble
        do_reset();
        for (int c = 0; c < 3; c++) begin
            both(1, 0, 8'(c), 8'h0, 64'(c), 64'h0);
            #1 chk("r032.ready0", 64'(r0[0]), 64'd1);
            tick();
        end
        both(0, 1, 8'h0, 8'h44, 64'h0, 64'h44);
        #1 chk("r032.ready1", 64'(r1[0]), 64'd1);
        tick();
        both(0, 0, 0, 0, 0, 0);
        #1 chk("r032.wr_en", 64'(we[0]), 64'd1);
        tick();
        both(1, 1, 8'h55, 8'h66, 64'h55, 64'h66);
        #1 chk("r032.prio0", 64'(r0[0]), 64'd1);
        tick();
        // Idle after an OWN1 burst returns priority to port 0
        do_reset();
        both(0, 1, 8'h0, 8'h70, 64'h0, 64'h70);
        tick();
        tick();
        both(0, 0, 0, 0, 0, 0);
        tick();
        both(1, 1, 8'h71, 8'h72, 64'h71, 64'h72);
        #1 chk("r033.owner", 64'(ow[0]), 64'd0);
        chk("r033.ready0", 64'(r0[0]), 64'd1);
        tick();
        // Reset in the middle of a port 1 burst
        do_reset();
        both(0, 1, 8'h0, 8'h90, 64'h0, 64'h90);
        tick();
        rst = 1'b0;
        #1 chk("r034.ready0", 64'(r0[0]), 64'd0);
        chk("r034.ready1", 64'(r1[0]), 64'd0);
        tick();
        rst = 1'b1;
        both(1, 1, 8'h91, 8'h92, 64'h91, 64'h92);
        #1 chk("r034.wr_en", 64'(we[0]), 64'd0);
        chk("r034.ready0", 64'(r0[0]), 64'd1);
        tick();
        // Randomized traffic; a pending request keeps its payload until granted
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!(v0[i] && m_g[i] != 0)) begin
                    v0[i] = $urandom_range(0, 3) != 0;
                    a0[i] = 8'($urandom);
                    d0[i] = {$urandom, $urandom};
                end
                if (!(v1[i] && m_g[i] != 1)) begin
                    v1[i] = $urandom_range(0, 3) != 0;
                    a1[i] = 8'($urandom);
                    d1[i] = {$urandom, $urandom};
                end
            end
            rst = $urandom_range(0, 60) != 0;
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bram_wr_arbiter.md
BRAM_WR_ARBITER -- requirements
Module: bram_wr_arbiter

Interface
REQ-001 Parameter ABITS, default 8: BRAM address width.
REQ-002 Parameter DBITS, default 64: BRAM data width.
REQ-003 Parameter MAXBURST, default 16: max consecutive grants to one port while the other port is waiting; legal range 1..255.
REQ-004 clk  input  1  single clock for the block; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-low.
REQ-006 req0_valid  input  1  port 0 (compute engine) write request.
REQ-007 req0_addr  input  ABITS  port 0 write address.
REQ-008 req0_data  input  DBITS  port 0 write data.
REQ-009 req0_ready  output  1  port 0 grant; a transfer occurs when valid and ready are both high.
REQ-010 req1_valid / req1_addr / req1_data / req1_ready: port 1 (serial loader), same widths and meanings as port 0.
REQ-011 wr_addr  output  ABITS  BRAM write address, registered.
REQ-012 wr_data  output  DBITS  BRAM write data, registered.
REQ-013 wr_en  output  1  BRAM write enable, registered.
REQ-014 owner  output  2  current state: 00 IDLE, 01 OWN0, 10 OWN1.

Function
REQ-015 reqK_ready SHALL be combinational from current state and both valids; at most one ready high per cycle; readyK never high while reqK_valid is low.
REQ-016 Requesters SHALL hold addr/data stable while valid and not ready; the arbiter does not buffer.
REQ-017 State machine states: IDLE, OWN0, OWN1; internal prio bit (reset 0) and burst counter cnt (8 bits, saturating at MAXBURST).
REQ-018 IDLE: single valid port K -> grant K, go OWNK, cnt=1; both valid -> grant port prio, go OWN(prio), cnt=1; none valid -> stay IDLE.
REQ-019 OWNK, reqK_valid high, and (other port not valid or cnt<MAXBURST) -> grant K, cnt=min(cnt+1,MAXBURST).
REQ-020 OWNK, other port valid, and (reqK_valid low or cnt==MAXBURST) -> grant other, go OWN(other), cnt=1, prio=K.
REQ-021 OWNK, neither port valid -> no grant, go IDLE, prio=other port.
REQ-022 Each transfer SHALL appear on wr_en/wr_addr/wr_data exactly one cycle after the handshake cycle (latency 1), in grant order.
REQ-023 wr_en SHALL be low in any cycle following a cycle with no transfer; wr_addr/wr_data hold their last values when wr_en is low.
REQ-024 Back-to-back writes to the same address from different ports are emitted in grant order with no merging or reordering; last write wins in BRAM.
REQ-025 Sustained throughput SHALL be one write per cycle when any port is valid; no bubble on ownership switch.
REQ-026 With MAXBURST=1 and both ports continuously valid, grants SHALL strictly alternate.

Reset
REQ-027 While rst is low at a rising edge: state=IDLE, prio=0, cnt=0, wr_en=0, wr_addr=0, wr_data=0.
REQ-028 While rst is low, req0_ready and req1_ready SHALL be 0; a handshake presented during reset is not accepted and produces no write.
REQ-029 Reset asserted mid-burst SHALL discard ownership; the first grant after rst deasserts follows the IDLE rules with prio=0.

Verification (MAXBURST=4, ABITS=8, DBITS=64 unless stated)
REQ-030 After reset, only port 1 valid with addr 0x10, data 0xA5 -> req1_ready=1 the same cycle; next cycle wr_en=1, wr_addr=0x10, wr_data=0xA5; owner=10.
REQ-031 Both ports valid from IDLE continuously for 10 cycles -> grant sequence 0,0,0,0,1,1,1,1,0,0; wr_en high on all 10 following cycles.
REQ-032 Port 0 valid for 3 cycles, drops, port 1 valid next cycle -> grants 0,0,0,1 with no bubble; prio=0 afterwards; both valid from IDLE then -> port 0 granted.
REQ-033 Both ports idle one cycle after an OWN1 burst -> owner=00; both valid next -> port 0 granted (prio=0).
REQ-034 Reset asserted on the 2nd cycle of a port-1 burst -> both readies 0 during reset, wr_en 0 the next cycle, first grant after release is port 0 when both valid.
REQ-035 MAXBURST=1, both ports valid 6 cycles, port 0 addrs 0..2, port 1 addrs 0x80..0x82 -> wr_addr sequence 0x00,0x80,0x01,0x81,0x02,0x82.
